// File: rtl/hazard_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared pipeline types for the decode / hazard / execute slice.
//   MICROCODE_W, INST_DATA_W : field widths of a pipeline stage
//   MICROCODE_NOP            : all-zero microcode, i.e. a bubble
//   stage_t                  : one stage register {microcode, instruction_data}
//   STAGE_BUBBLE             : a bubble (no rs checks, no register write)
//   make_stage()             : packs the two fields into a stage_t
// ---------------------------------------------------------------------------
package pipeline_pkg;

    localparam int MICROCODE_W = 25;
    localparam int INST_DATA_W = 25;

    localparam logic [MICROCODE_W-1:0] MICROCODE_NOP = {MICROCODE_W{1'b0}};

    typedef struct packed {
        logic [MICROCODE_W-1:0] microcode;
        logic [INST_DATA_W-1:0] instruction_data;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '{
        microcode:        MICROCODE_NOP,
        instruction_data: {INST_DATA_W{1'b0}}
    };

    function automatic stage_t make_stage(
        input logic [MICROCODE_W-1:0] mc,
        input logic [INST_DATA_W-1:0] idata
    );
        stage_t st;
        st.microcode        = mc;
        st.instruction_data = idata;
        return st;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_if
// Decode -> hazard_stall_ctrl instruction handshake.
//   in_valid            : decode offers an instruction
//   in_ready            : hazard_stall_ctrl accepts (low while stalling)
//   in_microcode        : microcode of the offered instruction
//   in_instruction_data : rd/rs1/rs2/imm packing of the offered instruction
// Modports: master = decode side, slave = hazard_stall_ctrl side.
// ---------------------------------------------------------------------------
interface hazard_stall_ctrl_if import pipeline_pkg::*; ();

    logic                   in_valid;
    logic                   in_ready;
    logic [MICROCODE_W-1:0] in_microcode;
    logic [INST_DATA_W-1:0] in_instruction_data;

    modport master (
        output in_valid,
        output in_microcode,
        output in_instruction_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_microcode,
        input  in_instruction_data,
        output in_ready
    );

endinterface

// File: rtl/hazard_stall_ctrl_counter.sv
// ---------------------------------------------------------------------------
// hazard_stall_counter
// Stall-window counter for hazard_stall_ctrl.
//   clk, rst_n        : clock, async active-low reset
//   flush             : branch redirect, clears the window
//   data_dependency   : hazard flag from the detector
//   stall             : data_dependency | window open (combinational)
//   cnt_nz            : registered "window open" (counter nonzero)
//   stall_cycle_count : saturating count of stall edges
//                       (only with HAZARD_PERF_CNT_EN defined)
// A hazard seen with the window closed loads STALL_CYCLES-1; that edge is
// itself the first hold edge, so the window covers the remaining ones.
// ---------------------------------------------------------------------------
module hazard_stall_counter #(
    parameter int STALL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        data_dependency,
    output logic        stall,
    output logic        cnt_nz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0] stall_cycle_count
`endif
);

    localparam int CNT_W = $clog2(STALL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             cnt_nz_r;

    assign stall  = data_dependency | cnt_nz_r;
    assign cnt_nz = cnt_nz_r;

    // Next counter value: flush clears, hazard loads, otherwise count down.
    always_comb begin
        cnt_next_s = cnt_r;
        if (flush) begin
            cnt_next_s = CNT_ZERO;
        end else if (data_dependency && !cnt_nz_r) begin
            cnt_next_s = CNT_LOAD;
        end else if (cnt_nz_r) begin
            cnt_next_s = cnt_r - CNT_ONE;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Counter register and its registered nonzero flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= CNT_ZERO;
            cnt_nz_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_next_s;
            cnt_nz_r <= (cnt_next_s != CNT_ZERO);
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] perf_r;

    // Saturating count of stall edges, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_r <= 16'd0;
        end else if (stall && (perf_r != 16'hFFFF)) begin
            perf_r <= perf_r + 16'd1;
        end else begin
            perf_r <= perf_r;
        end
    end

    assign stall_cycle_count = perf_r;
`endif

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
// Owns the s0..s3 pipeline registers and resolves read-after-write hazards.
// On a hazard s0 holds, s1 receives bubbles and s2/s3 keep draining until
// the stall window closes. Flush kills s0/s1 and closes the window.
//   clk, rst_n                  : clock, async active-low reset
//   dec (slave)                 : decode handshake (in_ready = ~stall)
//   flush                       : branch redirect
//   data_dependency             : hazard flag from the detector
//   microcode_s0..s3            : stage microcode registers
//   instruction_data_s0..s3     : stage instruction-data registers
//   currently_blocked           : registered, high while the window is open
//   stall_cycle_count           : only with HAZARD_PERF_CNT_EN defined
// Optional feature macro: HAZARD_PERF_CNT_EN.
// ---------------------------------------------------------------------------
module hazard_stall_ctrl import pipeline_pkg::*; #(
    parameter int STALL_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hazard_stall_ctrl_if.slave     dec,
    input  logic                   flush,
    input  logic                   data_dependency,
    output logic [MICROCODE_W-1:0] microcode_s0,
    output logic [MICROCODE_W-1:0] microcode_s1,
    output logic [MICROCODE_W-1:0] microcode_s2,
    output logic [MICROCODE_W-1:0] microcode_s3,
    output logic [INST_DATA_W-1:0] instruction_data_s0,
    output logic [INST_DATA_W-1:0] instruction_data_s1,
    output logic [INST_DATA_W-1:0] instruction_data_s2,
    output logic [INST_DATA_W-1:0] instruction_data_s3,
    output logic                   currently_blocked
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]            stall_cycle_count
`endif
);

    logic   stall_s;
    logic   cnt_nz_s;
    stage_t s0_r, s1_r, s2_r, s3_r;
    stage_t s0_next_s, s1_next_s, s2_next_s, s3_next_s;

    hazard_stall_counter #(
        .STALL_CYCLES (STALL_CYCLES)
    ) u_counter (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .data_dependency   (data_dependency),
        .stall             (stall_s),
        .cnt_nz            (cnt_nz_s)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycle_count (stall_cycle_count)
`endif
    );

    assign dec.in_ready      = ~stall_s;
    assign currently_blocked = cnt_nz_s;

    // Stage steering; s2/s3 always advance so the writer keeps draining.
    always_comb begin
        s3_next_s = s2_r;
        s2_next_s = s1_r;
        s1_next_s = STAGE_BUBBLE;
        s0_next_s = STAGE_BUBBLE;
        if (flush) begin
            // Accepted input (if any) is discarded on a redirect.
            s1_next_s = STAGE_BUBBLE;
            s0_next_s = STAGE_BUBBLE;
        end else if (stall_s) begin
            s1_next_s = STAGE_BUBBLE;
            s0_next_s = s0_r;
        end else if (dec.in_valid) begin
            s1_next_s = s0_r;
            s0_next_s = make_stage(dec.in_microcode, dec.in_instruction_data);
        end else begin
            s1_next_s = s0_r;
            s0_next_s = STAGE_BUBBLE;
        end
    end

    // Stage registers; reset fills the pipe with bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_r <= STAGE_BUBBLE;
            s1_r <= STAGE_BUBBLE;
            s2_r <= STAGE_BUBBLE;
            s3_r <= STAGE_BUBBLE;
        end else begin
            s0_r <= s0_next_s;
            s1_r <= s1_next_s;
            s2_r <= s2_next_s;
            s3_r <= s3_next_s;
        end
    end

    assign microcode_s0        = s0_r.microcode;
    assign microcode_s1        = s1_r.microcode;
    assign microcode_s2        = s2_r.microcode;
    assign microcode_s3        = s3_r.microcode;
    assign instruction_data_s0 = s0_r.instruction_data;
    assign instruction_data_s1 = s1_r.instruction_data;
    assign instruction_data_s2 = s2_r.instruction_data;
    assign instruction_data_s3 = s3_r.instruction_data;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Directed vectors for hazard_stall_ctrl (STALL_CYCLES = 3). Each driven
// cycle pushes the hand-computed state expected in that cycle; a monitor
// pops and compares on the falling clock edge (and on async reset drop).
// Instruction data is derived from the microcode tag by idata().
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        data_dependency;
    logic [24:0] microcode_s0, microcode_s1, microcode_s2, microcode_s3;
    logic [24:0] instruction_data_s0, instruction_data_s1;
    logic [24:0] instruction_data_s2, instruction_data_s3;
    logic        currently_blocked;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycle_count;
`endif

    hazard_stall_ctrl_if bus ();

    hazard_stall_ctrl #(.STALL_CYCLES(3)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .dec                 (bus),
        .flush               (flush),
        .data_dependency     (data_dependency),
        .microcode_s0        (microcode_s0),
        .microcode_s1        (microcode_s1),
        .microcode_s2        (microcode_s2),
        .microcode_s3        (microcode_s3),
        .instruction_data_s0 (instruction_data_s0),
        .instruction_data_s1 (instruction_data_s1),
        .instruction_data_s2 (instruction_data_s2),
        .instruction_data_s3 (instruction_data_s3),
        .currently_blocked   (currently_blocked)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycle_count   (stall_cycle_count)
`endif
    );

    typedef struct {
        string       tag;
        logic [24:0] s0, s1, s2, s3;
        logic        blocked;
        logic        ready;
        logic        chk_perf;
        logic [15:0] perf;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        perf_chk_next = 1'b0;
    logic [15:0] perf_next = 16'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [24:0] idata(input logic [24:0] mc);
        return (mc == 25'd0) ? 25'd0 : (mc ^ 25'h1555555);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic [24:0] e0, input logic [24:0] e1,
                                input logic [24:0] e2, input logic [24:0] e3,
                                input logic eb, input logic er);
        exp_t e;
        e.tag = tag; e.s0 = e0; e.s1 = e1; e.s2 = e2; e.s3 = e3;
        e.blocked = eb; e.ready = er; e.chk_perf = 1'b0; e.perf = 16'd0;
        return e;
    endfunction

    // Drive one cycle's inputs and push the state expected during that cycle.
    task automatic cyc(input string tag, input logic v, input logic [24:0] mc,
                       input logic ff, input logic dd,
                       input logic [24:0] e0, input logic [24:0] e1,
                       input logic [24:0] e2, input logic [24:0] e3,
                       input logic eb, input logic er);
        exp_t e;
        @(posedge clk);
        #2;
        bus.in_valid            = v;
        bus.in_microcode        = mc;
        bus.in_instruction_data = idata(mc);
        flush                   = ff;
        data_dependency         = dd;
        e = mk(tag, e0, e1, e2, e3, eb, er);
        e.chk_perf = perf_chk_next;
        e.perf     = perf_next;
        perf_chk_next = 1'b0;
        sb.push_back(e);
    endtask

    // Monitor: compare the oldest expectation whenever the DUT is sampled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.tag, " s0_mc"}, 32'(microcode_s0), 32'(e.s0));
                chk({e.tag, " s1_mc"}, 32'(microcode_s1), 32'(e.s1));
                chk({e.tag, " s2_mc"}, 32'(microcode_s2), 32'(e.s2));
                chk({e.tag, " s3_mc"}, 32'(microcode_s3), 32'(e.s3));
                chk({e.tag, " s0_id"}, 32'(instruction_data_s0), 32'(idata(e.s0)));
                chk({e.tag, " s1_id"}, 32'(instruction_data_s1), 32'(idata(e.s1)));
                chk({e.tag, " s2_id"}, 32'(instruction_data_s2), 32'(idata(e.s2)));
                chk({e.tag, " s3_id"}, 32'(instruction_data_s3), 32'(idata(e.s3)));
                chk({e.tag, " blocked"}, 32'(currently_blocked), 32'(e.blocked));
                chk({e.tag, " in_ready"}, 32'(bus.in_ready), 32'(e.ready));
`ifdef HAZARD_PERF_CNT_EN
                if (e.chk_perf) begin
                    chk({e.tag, " perf"}, 32'(stall_cycle_count), 32'(e.perf));
                end
`endif
            end
        end
    end

    initial begin
        rst_n                   = 1'b0;
        bus.in_valid            = 1'b0;
        bus.in_microcode        = 25'd0;
        bus.in_instruction_data = 25'd0;
        flush                   = 1'b0;
        data_dependency         = 1'b0;

        // Reset state.
        perf_chk_next = 1'b1; perf_next = 16'd0;
        cyc("rst", 1'b0, 25'h0, 1'b0, 1'b0, 25'h0, 25'h0, 25'h0, 25'h0, 1'b0, 1'b1);
        @(posedge clk); #1; rst_n = 1'b1;

        // A: single instruction flows to s3 four edges after acceptance.
        cyc("a1", 1'b1, 25'h11, 1'b0, 1'b0, 25'h0,  25'h0,  25'h0,  25'h0,  1'b0, 1'b1);
        cyc("a2", 1'b0, 25'h0,  1'b0, 1'b0, 25'h11, 25'h0,  25'h0,  25'h0,  1'b0, 1'b1);
        cyc("a3", 1'b0, 25'h0,  1'b0, 1'b0, 25'h0,  25'h11, 25'h0,  25'h0,  1'b0, 1'b1);
        cyc("a4", 1'b0, 25'h0,  1'b0, 1'b0, 25'h0,  25'h0,  25'h11, 25'h0,  1'b0, 1'b1);
        cyc("a5", 1'b0, 25'h0,  1'b0, 1'b0, 25'h0,  25'h0,  25'h0,  25'h11, 1'b0, 1'b1);
        cyc("a6", 1'b0, 25'h0,  1'b0, 1'b0, 25'h0,  25'h0,  25'h0,  25'h0,  1'b0, 1'b1);

        // B: one-cycle hazard pulse at b4 with writer 22 in s1.
        cyc("b1",  1'b1, 25'h21, 1'b0, 1'b0, 25'h0,  25'h0,  25'h0,  25'h0,  1'b0, 1'b1);
        cyc("b2",  1'b1, 25'h22, 1'b0, 1'b0, 25'h21, 25'h0,  25'h0,  25'h0,  1'b0, 1'b1);
        cyc("b3",  1'b1, 25'h23, 1'b0, 1'b0, 25'h22, 25'h21, 25'h0,  25'h0,  1'b0, 1'b1);
        cyc("b4",  1'b1, 25'h24, 1'b0, 1'b1, 25'h23, 25'h22, 25'h21, 25'h0,  1'b0, 1'b0);
        cyc("b5",  1'b1, 25'h24, 1'b0, 1'b0, 25'h23, 25'h0,  25'h22, 25'h21, 1'b1, 1'b0);
        cyc("b6",  1'b1, 25'h24, 1'b0, 1'b0, 25'h23, 25'h0,  25'h0,  25'h22, 1'b1, 1'b0);
        perf_chk_next = 1'b1; perf_next = 16'd3;
        cyc("b7",  1'b1, 25'h24, 1'b0, 1'b0, 25'h23, 25'h0,  25'h0,  25'h0,  1'b0, 1'b1);
        cyc("b8",  1'b0, 25'h0,  1'b0, 1'b0, 25'h24, 25'h23, 25'h0,  25'h0,  1'b0, 1'b1);
        cyc("b9",  1'b0, 25'h0,  1'b0, 1'b0, 25'h0,  25'h24, 25'h23, 25'h0,  1'b0, 1'b1);
        cyc("b10", 1'b0, 25'h0,  1'b0, 1'b0, 25'h0,  25'h0,  25'h24, 25'h23, 1'b0, 1'b1);
        cyc("b11", 1'b0, 25'h0,  1'b0, 1'b0, 25'h0,  25'h0,  25'h0,  25'h24, 1'b0, 1'b1);
        cyc("b12", 1'b0, 25'h0,  1'b0, 1'b0, 25'h0,  25'h0,  25'h0,  25'h0,  1'b0, 1'b1);

        // C: hazard held high across the window; no reload, release after.
        cyc("c1",  1'b1, 25'h31, 1'b0, 1'b0, 25'h0,  25'h0,  25'h0,  25'h0,  1'b0, 1'b1);
        cyc("c2",  1'b1, 25'h32, 1'b0, 1'b1, 25'h31, 25'h0,  25'h0,  25'h0,  1'b0, 1'b0);
        cyc("c3",  1'b1, 25'h32, 1'b0, 1'b1, 25'h31, 25'h0,  25'h0,  25'h0,  1'b1, 1'b0);
        cyc("c4",  1'b1, 25'h32, 1'b0, 1'b1, 25'h31, 25'h0,  25'h0,  25'h0,  1'b1, 1'b0);
        cyc("c5",  1'b1, 25'h32, 1'b0, 1'b0, 25'h31, 25'h0,  25'h0,  25'h0,  1'b0, 1'b1);
        perf_chk_next = 1'b1; perf_next = 16'd6;
        cyc("c6",  1'b0, 25'h0,  1'b0, 1'b0, 25'h32, 25'h31, 25'h0,  25'h0,  1'b0, 1'b1);
        cyc("c7",  1'b0, 25'h0,  1'b0, 1'b0, 25'h0,  25'h32, 25'h31, 25'h0,  1'b0, 1'b1);
        cyc("c8",  1'b0, 25'h0,  1'b0, 1'b0, 25'h0,  25'h0,  25'h32, 25'h31, 1'b0, 1'b1);
        cyc("c9",  1'b0, 25'h0,  1'b0, 1'b0, 25'h0,  25'h0,  25'h0,  25'h32, 1'b0, 1'b1);
        cyc("c10", 1'b0, 25'h0,  1'b0, 1'b0, 25'h0,  25'h0,  25'h0,  25'h0,  1'b0, 1'b1);

        // D: flush together with a hazard, then a flush discarding an input.
        cyc("d1", 1'b1, 25'h41, 1'b0, 1'b0, 25'h0,  25'h0,  25'h0,  25'h0,  1'b0, 1'b1);
        cyc("d2", 1'b1, 25'h42, 1'b0, 1'b0, 25'h41, 25'h0,  25'h0,  25'h0,  1'b0, 1'b1);
        cyc("d3", 1'b1, 25'h43, 1'b1, 1'b1, 25'h42, 25'h41, 25'h0,  25'h0,  1'b0, 1'b0);
        cyc("d4", 1'b0, 25'h0,  1'b0, 1'b0, 25'h0,  25'h0,  25'h41, 25'h0,  1'b0, 1'b1);
        cyc("d5", 1'b0, 25'h0,  1'b0, 1'b0, 25'h0,  25'h0,  25'h0,  25'h41, 1'b0, 1'b1);
        cyc("d6", 1'b1, 25'h51, 1'b1, 1'b0, 25'h0,  25'h0,  25'h0,  25'h0,  1'b0, 1'b1);
        cyc("d7", 1'b0, 25'h0,  1'b0, 1'b0, 25'h0,  25'h0,  25'h0,  25'h0,  1'b0, 1'b1);

        // E: async reset mid-window (counter at 1) clears everything at once.
        cyc("e1", 1'b1, 25'h61, 1'b0, 1'b0, 25'h0,  25'h0,  25'h0,  25'h0,  1'b0, 1'b1);
        cyc("e2", 1'b1, 25'h62, 1'b0, 1'b1, 25'h61, 25'h0,  25'h0,  25'h0,  1'b0, 1'b0);
        cyc("e3", 1'b1, 25'h62, 1'b0, 1'b0, 25'h61, 25'h0,  25'h0,  25'h0,  1'b1, 1'b0);
        cyc("e4", 1'b1, 25'h62, 1'b0, 1'b0, 25'h61, 25'h0,  25'h0,  25'h0,  1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sb.push_back(mk("e_arst", 25'h0, 25'h0, 25'h0, 25'h0, 1'b0, 1'b1));
        perf_chk_next = 1'b1; perf_next = 16'd0;
        cyc("e5", 1'b0, 25'h0,  1'b0, 1'b0, 25'h0,  25'h0,  25'h0,  25'h0,  1'b0, 1'b1);
        @(posedge clk); #1; rst_n = 1'b1;
        perf_chk_next = 1'b1; perf_next = 16'd0;
        cyc("e6", 1'b1, 25'h71, 1'b0, 1'b0, 25'h0,  25'h0,  25'h0,  25'h0,  1'b0, 1'b1);
        cyc("e7", 1'b0, 25'h0,  1'b0, 1'b0, 25'h71, 25'h0,  25'h0,  25'h0,  1'b0, 1'b1);
        cyc("e8", 1'b0, 25'h0,  1'b0, 1'b0, 25'h0,  25'h71, 25'h0,  25'h0,  1'b0, 1'b1);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 8; i++) begin
            if (sb.size() != 0) begin
                @(negedge clk);
                #2;
            end
        end
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Owns the s0–s3 pipeline registers (microcode and instruction data) and resolves read-after-write hazards flagged by the data dependency detector. On a flagged dependency it holds s0, injects bubbles into s1, and lets s1–s3 drain for a fixed stall window. It drives `currently_blocked` back to the detector so the detector does not re-trigger during the window. It sits directly downstream of fetch/decode and feeds the stage inputs of the detector and the execute/writeback stages.

## Interface
Parameters:
- `STALL_CYCLES`, default 3: total stall edges per hazard (≥1); matches s1→s3 writeback distance.

Ports:
- `clk` in 1: sole clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: decode offers an instruction.
- `in_ready` out 1: this block accepts; combinational, `~stall`.
- `in_microcode` in 25: microcode for the offered instruction.
- `in_instruction_data` in 25: rd/rs1/rs2/imm packing for the offered instruction.
- `flush` in 1: branch redirect; kill s0 and s1.
- `data_dependency` in 1: hazard flag from detector (combinational from this block's outputs).
- `microcode_s0`..`microcode_s3` out 25 each: stage registers.
- `instruction_data_s0`..`instruction_data_s3` out 25 each: stage registers.
- `currently_blocked` out 1: registered; high while the stall counter is nonzero.
- `stall_cycle_count` out 16: present only with `HAZARD_PERF_CNT_EN`.

## Operation
- Bubble = microcode `MICROCODE_NOP` (all zero) with instruction data zero. A bubble has no rs checks and no register write.
- `stall = data_dependency | (cnt != 0)`.
- Stall counter `cnt` is `$clog2(STALL_CYCLES+1)` bits wide.
- Normal edge (`~stall`):
  - s3←s2, s2←s1, s1←s0.
  - s0←input if `in_valid`, else bubble.
- Stall edge:
  - s0 holds; s1←bubble; s2←s1; s3←s2.
  - Input is not accepted.
- Counter load: `data_dependency` with `cnt==0` loads `cnt←STALL_CYCLES-1`.
- Counter decrement: `cnt!=0` decrements by 1, saturating at 0.
- `currently_blocked` is `cnt != 0`. The detector masks itself with it, so a dependency can re-fire only after the window ends.
- `flush`:
  - Overrides everything: s0←bubble, s1←bubble, `cnt←0`.
  - s2/s3 advance normally (s3←s2, s2←s1 pre-flush value).
  - `in_ready` stays `~stall` but the accepted input is discarded.
  - Flush in the same cycle as `data_dependency`: flush wins, no counter load.
- `STALL_CYCLES==1`: no blocked cycles; a single hold edge.

## Timing
- Reset: all stage outputs 0 (bubble), `cnt` 0, `currently_blocked` 0, `stall_cycle_count` 0. `in_ready` is 1 once `data_dependency` is 0.
- Latency: input accepted at edge E appears in s0 after E and in s3 three edges later, absent stalls.
- Hazard at cycle t with writer in s1 (default parameter):
  - Hold edges at end of t, t+1, t+2.
  - `currently_blocked` is high in t+1 and t+2.
  - Writer is in s3 in t+2 and writes at its end.
  - At t+3, `cnt==0` and the detector re-evaluates; s0 advances at end of t+3.
- Reset asserted mid-stall: immediate clear; no residual block.

## Configuration
- `HAZARD_PERF_CNT_EN`
  - Defined: adds a 16-bit `stall_cycle_count` output. It increments on every stall edge, saturates at 16'hFFFF, and is cleared only by reset.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `pipeline_pkg`:
  - `MICROCODE_W=25`, `INST_DATA_W=25`, `MICROCODE_NOP='0`.
  - Typedef `stage_t` struct {microcode, instruction_data}, shared with the decoders and detector.
- Sub-module `hazard_stall_counter`: load/decrement/flush-clear counter producing `cnt_nz`; the optional perf counter lives there.

## Test plan
- Reset release, `in_valid`=1 with microcode 25'h00_0011, no hazards → the same value is in s3 exactly 4 edges after acceptance; `in_ready` stays 1.
- `data_dependency` pulsed for 1 cycle at t → s0 is held for 3 edges; s1 is a bubble at t+1..t+3; `currently_blocked` is 1 only in t+1 and t+2; `in_ready`=0 in t..t+2.
- `data_dependency` held at 1 through t+2 → no reload and no extra stall; release at t+3.
- `flush` and `data_dependency` in the same cycle → s0=s1=0 next cycle, `currently_blocked` stays 0, and s2 gets the old s1.
- `rst_n` dropped asynchronously mid-window (`cnt`=1) → all outputs are 0 immediately without waiting for a clock edge.
- With `HAZARD_PERF_CNT_EN`, two hazards separated by idle cycles → `stall_cycle_count`=6.
